pipe_fetch_pc: RTL
==================

# pipe_fetch_pc

Instruction-fetch PC stage of the pipelined MIPS CPU. It holds the program counter, drives the instruction-memory read port, and applies branch/jump redirects with MIPS delay-slot semantics. It stalls on `waitrequest` or a hazard (`IF_ID_Write` low), and halts the core once control transfers to address 0. `IF_Reg_PC` feeds the IF/ID register and the link-PC pipeline, which must see the same stall behaviour.

## Interface
Parameters:
- `RESET_VECTOR`, 32'hBFC00000: PC value after reset.
- `DRAIN_CYCLES`, 4: un-stalled cycles counted after halt detection before `active` falls.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `waitrequest`  in  1  memory stall, shared with the pipeline; freezes PC and all counters.
- `IF_ID_Write`  in  1  hazard-unit enable; 0 holds the PC.
- `redirect_valid`  in  1  ID stage resolved a taken branch/jump this cycle.
- `redirect_target`  in  32  target address; bits [1:0] ignored and treated as 0.
- `instr_read`  out  1  instruction read request.
- `instr_address`  out  32  fetch address, equal to the PC.
- `IF_Reg_PC`  out  32  PC of the instruction fetched this cycle, equal to the PC.
- `active`  out  1  core running; 0 once halted and drained.

## Operation
- States: RUN, DRAIN, HALTED.
- Advance condition: `adv = (state==RUN) & !waitrequest & IF_ID_Write`.
- Next-PC priority on `adv`:
  1. `redirect_valid` ? `{redirect_target[31:2],2'b00}`
  2. `pend_valid` ? `pend_target`
  3. PC+4, modulo 2^32 (0xFFFFFFFC+4 = 0, which triggers halt).
- When `adv` is taken, `pend_valid` clears.
- Delay slot handling:
  - A redirect arrives while the delay-slot instruction is in IF, so the next PC is the target. This handling is correct with no extra logic.
  - If `redirect_valid` is asserted while `adv`=0, the target is captured into the pending register (`pend_valid`=1). A later redirect before the advance overwrites it (latest wins).
- Halt:
  - When an advance would load PC=0, the PC loads 0, `state`→DRAIN, `instr_read`→0, and the drain counter loads 0.
  - In DRAIN, the counter increments on each cycle with `waitrequest`=0.
  - When the count reaches `DRAIN_CYCLES`-1 and is incremented, `state`→HALTED and `active`→0.
  - HALTED is terminal until reset.
- In DRAIN/HALTED:
  - `redirect_valid` is ignored.
  - The PC holds 0.
  - `IF_Reg_PC` = 0.
- `instr_read` = (`state`==RUN). It is asserted continuously in RUN, including while stalled. The address is held stable while `waitrequest` is high.

## Timing
- Reset (async assertion, sync-free release):
  - PC = `RESET_VECTOR`
  - `state`=RUN, `pend_valid`=0, `pend_target`=0, drain counter=0
  - `active`=1, `instr_read`=1, `instr_address`=`IF_Reg_PC`=`RESET_VECTOR`.
- A mid-operation reset discards pending redirects and drain progress immediately.
- PC update latency: one cycle. A redirect sampled at edge N makes `instr_address`=target after edge N.
- Outputs are registered PC or state decode, with no combinational path from inputs to outputs.
- Simultaneous events:
  - Redirect together with `waitrequest`=1: captured to pending, not lost.
  - Redirect together with `pend_valid`=1 and `adv`: the new redirect wins and the pending register clears.
  - Redirect to 0 while stalled: pends; halt is entered on the eventual advance.
- `waitrequest` overrides `IF_ID_Write`; nothing changes while it is high except pending capture.

## Test plan
- Reset, then 3 cycles with `adv`=1 → `instr_address` goes BFC00000, BFC00004, BFC00008, BFC0000C; `active`=1, `instr_read`=1.
- PC=BFC00010; `redirect_valid`=1, target=BFC00100 → next `IF_Reg_PC`=BFC00100; next cycle BFC00104.
- PC=BFC00010; `waitrequest`=1 for 3 cycles with a 1-cycle redirect to 80000000 during the first → PC holds BFC00010, then loads 80000000 on the first advance (not BFC00014).
- `IF_ID_Write`=0 for 2 cycles → PC holds. Two redirects in successive stalled cycles (A0000000 then A0000040) → PC=A0000040 after release.
- Redirect to 0x00000000 → `instr_read`=0 next cycle; `active` falls after 4 un-stalled cycles, with an injected `waitrequest` cycle extending this to 5. Later redirects are ignored.
- Assert `rst_n`=0 mid-DRAIN and mid-pending → PC=BFC00000, `active`=1, no pending redirect is applied after release; target BFC0001F is fetched as BFC0001C.

Source files
------------

// File: rtl/pipe_fetch_pc.sv
// Instruction-fetch PC stage: holds the PC, drives the instruction read port,
// applies branch/jump redirects (latched while stalled) and halts on a jump to 0.
module pipe_fetch_pc #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int          DRAIN_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        waitrequest,
    input  logic        IF_ID_Write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        instr_read,
    output logic [31:0] instr_address,
    output logic [31:0] IF_Reg_PC,
    output logic        active
);

    localparam int CW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    state_t        state, state_nxt;
    logic [31:0]   pc, pc_nxt;
    logic          pend_valid, pend_valid_nxt;
    logic [31:0]   pend_target, pend_target_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          adv;
    logic [31:0]   tgt_aligned;
    logic [31:0]   fetch_next;
    logic          unused_low_bits;

    assign unused_low_bits = ^redirect_target[1:0];
    assign tgt_aligned     = {redirect_target[31:2], 2'b00};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            pc          <= RESET_VECTOR;
            pend_valid  <= 1'b0;
            pend_target <= 32'd0;
            cnt         <= '0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_valid  <= pend_valid_nxt;
            pend_target <= pend_target_nxt;
            cnt         <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        pc_nxt          = pc;
        pend_valid_nxt  = pend_valid;
        pend_target_nxt = pend_target;
        cnt_nxt         = cnt;
        adv             = (state == RUN) && !waitrequest && IF_ID_Write;
        fetch_next      = redirect_valid ? tgt_aligned :
                          pend_valid     ? pend_target : pc + 32'd4;
        case (state)
            RUN: begin
                if (adv) begin
                    pc_nxt         = fetch_next;
                    pend_valid_nxt = 1'b0;
                    if (fetch_next == 32'd0) begin
                        state_nxt = DRAIN;
                        cnt_nxt   = '0;
                    end
                end else if (redirect_valid) begin
                    // Redirect seen while stalled: remember it, latest one wins.
                    pend_valid_nxt  = 1'b1;
                    pend_target_nxt = tgt_aligned;
                end
            end
            DRAIN: begin
                if (!waitrequest) begin
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == LAST)
                        state_nxt = HALTED;
                end
            end
            default: state_nxt = HALTED;
        endcase
    end

    assign instr_read    = (state == RUN);
    assign active        = (state != HALTED);
    assign instr_address = pc;
    assign IF_Reg_PC     = pc;

endmodule
